gemm_tile_ctrl: RTL and testbench
=================================

GEMM_TILE_CTRL -- requirements
Module: gemm_tile_ctrl

Interface
REQ-001 Parameter AddrWidth, default 10: SRAM word-address width for A, B and C.
REQ-002 Parameter SizeAddrWidth, default 8: width of element-count size inputs.
REQ-003 Parameter TileM, default 4: tile rows; power of two.
REQ-004 Parameter TileN, default 4: tile columns; power of two.
REQ-005 Parameter TileK, default 4: tile depth; power of two.
REQ-006 Port clk_i, input, 1: single clock; all state changes on rising edge.
REQ-007 Port rst_i, input, 1: reset; asynchronous, active-high.
REQ-008 Port start_i, input, 1: launch request; sampled only in IDLE.
REQ-009 Port M_size_i, K_size_i, N_size_i, input, SizeAddrWidth each: matrix dimensions in elements; sampled on accepted start.
REQ-010 Port c_layout_i, input, 1: C tile order; 0 = tile-row-major, 1 = tile-column-major; sampled on accepted start.
REQ-011 Port sram_a_addr_o, sram_b_addr_o, output, AddrWidth each: read addresses; one-cycle read latency.
REQ-012 Port mac_valid_o, output, 1: SRAM read data is valid this cycle; datapath must accumulate.
REQ-013 Port acc_clear_o, output, 1: with mac_valid_o; datapath loads the product instead of accumulating (first K tile).
REQ-014 Port sram_c_addr_o, output, AddrWidth, and sram_c_we_o, output, 1: C tile write address and enable.
REQ-015 Port busy_o, output, 1, and done_o, output, 1: busy_o high from accept to done; done_o is a one-cycle completion pulse.
REQ-016 Port cycles_o, output, 32: cycle count of the last completed job.

Function
REQ-017 Tile counts Mt=ceil(M_size_i/TileM), Kt, Nt likewise, computed by shift/round-up at accept and held for the job.
REQ-018 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i; RUN->DRAIN after the final issue; DRAIN->DONE after 2 cycles; DONE->IDLE after 1 cycle.
REQ-019 If any size is 0 at accept: IDLE->DONE directly; no mac_valid_o, no sram_c_we_o.
REQ-020 RUN issues one (mt,nt,kt) triple per cycle, loop order mt outer, nt, kt inner; no stalls.
REQ-021 sram_a_addr_o = mt*Kt+kt; sram_b_addr_o = kt*Nt+nt; held at the last value outside RUN.
REQ-022 mac_valid_o is high exactly 1 cycle after each issue; acc_clear_o is high with it iff that issue had kt==0.
REQ-023 sram_c_we_o pulses exactly 2 cycles after each issue with kt==Kt-1, i.e. once per output tile.
REQ-024 C address: mt*Nt+nt when layout 0; nt*Mt+mt when layout 1; delayed to align with sram_c_we_o.
REQ-025 Total C writes per job = Mt*Nt; total issues = Mt*Kt*Nt; last write occurs in the final DRAIN cycle.
REQ-026 start_i is ignored in RUN, DRAIN and DONE; changing size/layout inputs mid-job has no effect.
REQ-027 cycles_o counts from the accept cycle through the DONE cycle inclusive and updates when done_o is asserted.
REQ-028 Address arithmetic is modulo 2^AddrWidth; overflow is the caller's responsibility and is not flagged.

Reset
REQ-029 On rst_i: state IDLE; all counters 0; every output 0, including cycles_o; effective immediately, with no clock edge required.
REQ-030 Reset mid-job aborts: no further sram_c_we_o or done_o pulses for that job.

Structure
REQ-031 Package gemm_pkg holds the state enum and the c_layout encoding constants.
REQ-032 One sub-module, gemm_tile_counter: a nested 3-level wrap counter with per-level limits and a last flag; instantiated once.

Verification
REQ-033 Sizes 8,8,8, tile 4, layout 0: 8 issues; C writes at addresses 0,1,2,3; acc_clear_o on issues 0,2,4,6; done_o 1 cycle after last write.
REQ-034 Sizes 8,4,12, layout 1: Mt=2, Nt=3, Kt=1; C address order 0,2,4,1,3,5; acc_clear_o on every mac_valid_o.
REQ-035 Sizes 5,6,7 (non-multiples): tile counts 2,2,2; 8 issues; 4 C writes; cycles_o = 8+2+1+1 = 12.
REQ-036 M_size_i=0: done_o exactly 1 cycle after accept; no we; cycles_o = 2.
REQ-037 start_i held high through a job: exactly one job runs; a second job starts the cycle after return to IDLE.
REQ-038 rst_i asserted mid-RUN: outputs 0 asynchronously; no done_o; next start produces a full correct job.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and encodings for the GEMM tile controller.
package gemm_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ordering of C tiles in the output SRAM.
    localparam logic C_LAYOUT_ROW = 1'b0;   // tile-row-major: mt*Nt+nt
    localparam logic C_LAYOUT_COL = 1'b1;   // tile-column-major: nt*Mt+mt

    // Issue -> mac_valid is one stage, issue -> C write is two.
    localparam int PIPE_STAGES = 2;

endpackage

// File: rtl/gemm_tile_counter.sv
// Three-level nested wrap counter: level 0 innermost, level 2 outermost.
// last is high while every level sits on its final value.
module gemm_tile_counter #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [2:0][W-1:0]   lim,
    output logic [2:0][W-1:0]   idx,
    output logic                last
);

    logic [2:0] at_max;
    logic [2:0] carry;

    // Per-level wrap detection and the ripple carry that advances outer levels.
    always_comb begin
        at_max = '0;
        carry  = '0;
        for (int l = 0; l < 3; l++) begin
            at_max[l] = (idx[l] == lim[l] - W'(1));
        end
        carry[0] = en;
        for (int l = 1; l < 3; l++) begin
            carry[l] = carry[l-1] & at_max[l-1];
        end
    end

    assign last = &at_max;

    // Index registers: a level steps when all inner levels wrap this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else begin
            for (int l = 0; l < 3; l++) begin
                if (carry[l]) begin
                    idx[l] <= at_max[l] ? '0 : idx[l] + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gemm_tile_ctrl.sv
// GEMM tile sequencer: walks (mt, nt, kt) tiles, drives A/B read addresses,
// MAC valid/clear strobes and aligned C tile writes, and times each job.
module gemm_tile_ctrl
    import gemm_pkg::*;
#(
    parameter int AddrWidth     = 10,
    parameter int SizeAddrWidth = 8,
    parameter int TileM         = 4,
    parameter int TileN         = 4,
    parameter int TileK         = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic                     c_layout_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic                     mac_valid_o,
    output logic                     acc_clear_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              cycles_o
);

    localparam int SW  = SizeAddrWidth;
    localparam int AW  = AddrWidth;
    localparam int LgM = $clog2(TileM);
    localparam int LgN = $clog2(TileN);
    localparam int LgK = $clog2(TileK);

    // ceil(size / 2^lg) by add-and-shift; one extra bit keeps the carry.
    function automatic logic [SW-1:0] tile_count(input logic [SW-1:0] size, input int lg);
        logic [SW:0] sum;
        sum = {1'b0, size} + (SW+1)'((1 << lg) - 1);
        return SW'(sum >> lg);
    endfunction

    state_t state, state_next;

    logic [SW-1:0] mt_tiles, nt_tiles, kt_tiles;
    logic          layout;

    logic accept, zero_job, issue, drain_last;
    logic cnt_clear, cnt_en, cnt_last;
    logic [2:0][SW-1:0] lim, idx;
    logic [SW-1:0] mt, nt, kt;

    logic [AW-1:0] a_now, b_now, c_now, a_hold, b_hold;

    logic [PIPE_STAGES:1]         vld_pipe;
    logic [PIPE_STAGES:1]         wb_pipe;
    logic [PIPE_STAGES:1][AW-1:0] caddr_pipe;
    logic                         clr_q;
    logic [31:0]                  cyc_cnt;

    assign accept   = (state == ST_IDLE) && start_i;
    assign zero_job = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    assign issue    = (state == ST_RUN);

    assign lim = {mt_tiles, nt_tiles, kt_tiles};
    assign mt  = idx[2];
    assign nt  = idx[1];
    assign kt  = idx[0];

    gemm_tile_counter #(.W(SW)) u_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (cnt_clear),
        .en    (cnt_en),
        .lim   (lim),
        .idx   (idx),
        .last  (cnt_last)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and counter control; start_i only matters in IDLE.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_clear  = 1'b1;
                    state_next = zero_job ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (cnt_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Job configuration captured at accept so mid-job input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mt_tiles <= '0;
            nt_tiles <= '0;
            kt_tiles <= '0;
            layout   <= C_LAYOUT_ROW;
        end else if (accept) begin
            mt_tiles <= tile_count(M_size_i, LgM);
            nt_tiles <= tile_count(N_size_i, LgN);
            kt_tiles <= tile_count(K_size_i, LgK);
            layout   <= c_layout_i;
        end
    end

    // Address arithmetic for the current issue, wrapping at 2^AddrWidth.
    always_comb begin
        a_now = AW'(mt) * AW'(kt_tiles) + AW'(kt);
        b_now = AW'(kt) * AW'(nt_tiles) + AW'(nt);
        c_now = '0;
        unique case (layout)
            C_LAYOUT_ROW: c_now = AW'(mt) * AW'(nt_tiles) + AW'(nt);
            C_LAYOUT_COL: c_now = AW'(nt) * AW'(mt_tiles) + AW'(mt);
            default:      c_now = '0;
        endcase
    end

    // Remember the last issued addresses so the read ports hold outside RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_hold <= '0;
            b_hold <= '0;
        end else if (issue) begin
            a_hold <= a_now;
            b_hold <= b_now;
        end
    end

    assign sram_a_addr_o = issue ? a_now : a_hold;
    assign sram_b_addr_o = issue ? b_now : b_hold;

    // Issue pipeline: stage 1 meets SRAM read data, stage 2 writes C.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe   <= '0;
            wb_pipe    <= '0;
            caddr_pipe <= '0;
            clr_q      <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[PIPE_STAGES-1:1], issue};
            wb_pipe    <= {wb_pipe[PIPE_STAGES-1:1], (kt == kt_tiles - SW'(1))};
            caddr_pipe <= {caddr_pipe[PIPE_STAGES-1:1], c_now};
            clr_q      <= (kt == '0);
        end
    end

    assign mac_valid_o   = vld_pipe[1];
    assign acc_clear_o   = vld_pipe[1] & clr_q;
    assign sram_c_we_o   = vld_pipe[PIPE_STAGES] & wb_pipe[PIPE_STAGES];
    assign sram_c_addr_o = caddr_pipe[PIPE_STAGES];

    // DRAIN lasts two cycles so the final C write lands before DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drain_last <= 1'b0;
        else       drain_last <= (state == ST_DRAIN) && !drain_last;
    end

    // Job timer: counts accept..DONE inclusive, published on entry to DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_cnt  <= '0;
            cycles_o <= '0;
        end else begin
            if (accept)                 cyc_cnt <= 32'd1;
            else if (state != ST_IDLE)  cyc_cnt <= cyc_cnt + 32'd1;
            if (state_next == ST_DONE && state != ST_DONE)
                cycles_o <= (accept ? 32'd0 : cyc_cnt) + 32'd2;
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Self-checking bench for gemm_tile_ctrl: directed table, hold/reset
// sequences and randomized jobs against a loop-level reference model.
module tb_gemm_tile_ctrl;

    localparam int AW   = 10;
    localparam int SW   = 8;
    localparam int T    = 4;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] m_sz, k_sz, n_sz;
    logic          lay;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic          mac_valid, acc_clear, c_we, busy, done;
    logic [31:0]   cycles;

    gemm_tile_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .M_size_i      (m_sz),
        .K_size_i      (k_sz),
        .N_size_i      (n_sz),
        .c_layout_i    (lay),
        .sram_a_addr_o (a_addr),
        .sram_b_addr_o (b_addr),
        .mac_valid_o   (mac_valid),
        .acc_clear_o   (acc_clear),
        .sram_c_addr_o (c_addr),
        .sram_c_we_o   (c_we),
        .busy_o        (busy),
        .done_o        (done),
        .cycles_o      (cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Per-cycle trace of one job, indexed by cycles after the accept cycle.
    logic [AW-1:0] tr_a [MAXC], tr_b [MAXC], tr_c [MAXC];
    logic          tr_mac [MAXC], tr_clr [MAXC], tr_we [MAXC], tr_busy [MAXC], tr_done [MAXC];
    logic [31:0]   tr_cyc [MAXC];

    // Observed summary of the last job.
    int obs_iss, obs_wr, obs_clr_mask, obs_cycles;
    int obs_cseq[$];

    // Runs one job from the current negedge (the accept cycle) and checks it.
    // hold keeps start high and swaps in the next job's inputs mid-job.
    task automatic run_job(input int m, input int k, input int n, input bit ly,
                           input bit hold, input int m2, input int k2, input int n2,
                           input bit ly2, input string tag);
        int mtn, ktn, ntn, R, drel, L, mac_i;
        int ea[$], eb[$], eclr[$], ewe[$], ec[$];
        int e_addr, e_mac, e_we, e_done, e_busy;
        bit exp_mac, exp_clr, exp_we;
        mtn = (m + T - 1) / T;
        ktn = (k + T - 1) / T;
        ntn = (n + T - 1) / T;
        R = (m == 0 || k == 0 || n == 0) ? 0 : mtn * ktn * ntn;
        if (R > 0) begin
            for (int i = 0; i < mtn; i++)
                for (int j = 0; j < ntn; j++)
                    for (int kk = 0; kk < ktn; kk++) begin
                        ea.push_back((i * ktn + kk) % (1 << AW));
                        eb.push_back((kk * ntn + j) % (1 << AW));
                        eclr.push_back(kk == 0);
                        ewe.push_back(kk == ktn - 1);
                        ec.push_back((ly ? (j * mtn + i) : (i * ntn + j)) % (1 << AW));
                    end
        end
        drel = (R == 0) ? 1 : R + 3;
        L = drel + 1;

        start = 1'b1;
        m_sz = SW'(m); k_sz = SW'(k); n_sz = SW'(n); lay = ly;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            if (!hold) begin
                if (c == 1) start = 1'b0;
                if (c == 2) begin
                    m_sz = SW'($urandom); k_sz = SW'($urandom);
                    n_sz = SW'($urandom); lay = 1'($urandom_range(0, 1));
                end
                if (c == 3 && R > 0) start = 1'b1;
                if (c == 4) start = 1'b0;
            end else if (c == 2) begin
                m_sz = SW'(m2); k_sz = SW'(k2); n_sz = SW'(n2); lay = ly2;
            end
            tr_a[c] = a_addr;  tr_b[c] = b_addr;  tr_c[c] = c_addr;
            tr_mac[c] = mac_valid; tr_clr[c] = acc_clear; tr_we[c] = c_we;
            tr_busy[c] = busy; tr_done[c] = done; tr_cyc[c] = cycles;
        end

        e_addr = 0; e_mac = 0; e_we = 0; e_done = 0; e_busy = 0;
        obs_iss = 0; obs_wr = 0; obs_clr_mask = 0; mac_i = 0;
        obs_cseq.delete();
        for (int c = 1; c <= L; c++) begin
            if (c <= R && (tr_a[c] !== AW'(ea[c-1]) || tr_b[c] !== AW'(eb[c-1]))) e_addr++;
            exp_mac = (R > 0) && c >= 2 && c <= R + 1;
            exp_clr = exp_mac && eclr[c-2] != 0;
            if (tr_mac[c] !== exp_mac || tr_clr[c] !== exp_clr) e_mac++;
            exp_we = (R > 0) && c >= 3 && c <= R + 2 && ewe[c-3] != 0;
            if (tr_we[c] !== exp_we || (exp_we && tr_c[c] !== AW'(ec[c-3]))) e_we++;
            if (tr_done[c] !== (c == drel)) e_done++;
            if (tr_busy[c] !== (c <= drel)) e_busy++;
            if (tr_mac[c] === 1'b1) begin
                if (tr_clr[c] === 1'b1 && mac_i < 32) obs_clr_mask |= (1 << mac_i);
                mac_i++;
                obs_iss++;
            end
            if (tr_we[c] === 1'b1) begin
                obs_wr++;
                obs_cseq.push_back(int'(tr_c[c]));
            end
        end
        obs_cycles = int'(tr_cyc[L]);
        if (R > 0) check({tag, " addr hold after run"}, tr_a[R+1], AW'(ea[R-1]));
        check({tag, " a/b addr cycles wrong"}, e_addr, 0);
        check({tag, " mac/clear cycles wrong"}, e_mac, 0);
        check({tag, " c write cycles wrong"}, e_we, 0);
        check({tag, " done cycles wrong"}, e_done, 0);
        check({tag, " busy cycles wrong"}, e_busy, 0);
        check({tag, " cycles_o at done"}, tr_cyc[drel], (R == 0) ? 2 : R + 4);
    endtask

    typedef struct {
        int m, k, n;
        bit ly;
        int iss, wr, cyc;
        int cseq[8];
        int clr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8, 8, 8, 1'b0, 8, 4, 12, '{0, 1, 2, 3, 0, 0, 0, 0}, 'h55};
        vecs[1] = '{8, 4, 12, 1'b1, 6, 6, 10, '{0, 2, 4, 1, 3, 5, 0, 0}, 'h3F};
        vecs[2] = '{5, 6, 7, 1'b0, 8, 4, 12, '{0, 1, 2, 3, 0, 0, 0, 0}, 'h55};
        vecs[3] = '{0, 8, 8, 1'b0, 0, 0, 2, '{0, 0, 0, 0, 0, 0, 0, 0}, 'h00};
        vecs[4] = '{4, 4, 4, 1'b1, 1, 1, 5, '{0, 0, 0, 0, 0, 0, 0, 0}, 'h01};
        vecs[5] = '{3, 0, 3, 1'b0, 0, 0, 2, '{0, 0, 0, 0, 0, 0, 0, 0}, 'h00};
        vecs[6] = '{16, 4, 4, 1'b0, 4, 4, 8, '{0, 1, 2, 3, 0, 0, 0, 0}, 'h0F};

        rst = 1'b1; start = 1'b0; m_sz = '0; k_sz = '0; n_sz = '0; lay = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset mac_valid", mac_valid, 0);
        check("reset c_we", c_we, 0);
        check("reset a_addr", a_addr, 0);
        check("reset c_addr", c_addr, 0);
        check("reset cycles", cycles, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].m, vecs[v].k, vecs[v].n, vecs[v].ly, 1'b0, 0, 0, 0, 1'b0,
                    $sformatf("vec%0d", v));
            check($sformatf("vec%0d issues", v), obs_iss, vecs[v].iss);
            check($sformatf("vec%0d c writes", v), obs_wr, vecs[v].wr);
            check($sformatf("vec%0d cycles_o held", v), obs_cycles, vecs[v].cyc);
            check($sformatf("vec%0d clear mask", v), obs_clr_mask, vecs[v].clr);
            for (int w = 0; w < vecs[v].wr; w++)
                check($sformatf("vec%0d c addr %0d", v, w),
                      (w < obs_cseq.size()) ? obs_cseq[w] : -1, vecs[v].cseq[w]);
            @(negedge clk);
        end

        // start held high: one job, then the next starts right after IDLE.
        run_job(8, 8, 8, 1'b0, 1'b1, 5, 6, 7, 1'b1, "hold first");
        check("hold first writes", obs_wr, 4);
        run_job(5, 6, 7, 1'b1, 1'b0, 0, 0, 0, 1'b0, "hold second");
        check("hold second cseq", (obs_cseq.size() == 4) ? obs_cseq[1] : -1, 2);
        @(negedge clk);

        // Reset mid-RUN aborts the job asynchronously.
        start = 1'b1; m_sz = 8'd8; k_sz = 8'd8; n_sz = 8'd8; lay = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre-reset mac_valid", mac_valid, 1);
        rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort mac_valid", mac_valid, 0);
        check("abort a_addr", a_addr, 0);
        check("abort c_we", c_we, 0);
        check("abort cycles", cycles, 0);
        @(negedge clk); rst = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (done === 1'b1 || c_we === 1'b1 || busy === 1'b1) stray++;
            end
            check("abort stray activity", stray, 0);
        end
        run_job(8, 8, 8, 1'b0, 1'b0, 0, 0, 0, 1'b0, "post reset");
        @(negedge clk);

        // Randomized jobs.
        for (int r = 0; r < 25; r++) begin
            run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                    1'b0, 0, 0, 0, 1'b0, $sformatf("rand%0d", r));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
